fp_align_stage: RTL and testbench
=================================

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width; MANT_W = FRAC_W+4 (hidden bit + fraction + guard/round/sticky).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), x and y (input, 1+EXP_W+FRAC_W, IEEE-754 operands).
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1).
REQ-007 SHALL have ports out_sign (output, 1, sign of the larger-magnitude operand) and out_sub (output, 1, sign_x XOR sign_y).
REQ-008 SHALL have ports out_exp (output, EXP_W, effective exponent of the larger operand), out_mant_big and out_mant_small (output, MANT_W each).
REQ-009 SHALL have ports out_nan (output, 1), out_inf (output, 1) and out_zero (output, 1, both operands zero).

Function
REQ-010 SHALL be a 2-stage pipeline. Stage 1: classify, compare magnitudes, swap. Stage 2: align shift with sticky. Latency 2 cycles, throughput 1/cycle.
REQ-011 SHALL transfer on in_valid&&in_ready and on out_valid&&out_ready only.
REQ-012 SHALL set in_ready = !(s1_valid && s2_valid && !out_ready); a stage advances when the stage downstream of it is empty or draining the same cycle.
REQ-013 SHALL hold out_valid and all output payload stable while out_valid && !out_ready.
REQ-014 SHALL pick "big" as the operand with the larger {exp,frac}; ties pick x; out_sign = sign of big.
REQ-015 SHALL treat the effective exponent as 1 with hidden bit 0 when the stored exponent is 0; otherwise stored exponent with hidden bit 1.
REQ-016 SHALL form out_mant_big = {hidden, frac, 3'b000}.
REQ-017 SHALL form out_mant_small = small mantissa shifted right by (exp_big - exp_small), with LSB = OR of the original LSB and all bits shifted out.
REQ-018 SHALL give out_mant_small = {0…0, sticky} for shift >= MANT_W, where sticky = OR of the small mantissa.
REQ-019 SHALL set out_nan if either operand is NaN, or if both are infinite with opposite signs.
REQ-020 SHALL otherwise set out_inf if either operand is infinite, with out_sign = sign of the infinite operand.
REQ-021 SHALL give out_nan priority over out_inf; mantissa fields are don't-care when either flag is set.

Reset
REQ-022 SHALL on rst clear both stage valids, so out_valid=0 and in_ready=1 on the next cycle; in-flight data is discarded.
REQ-023 SHALL on rst drive all payload outputs and flags to 0.
REQ-024 SHALL accept no input during the cycle rst is high.

Configuration
REQ-025 SHALL, with FP_ALIGN_FTZ_EN defined, treat subnormal inputs (exp=0, frac≠0) as signed zero: frac forced to 0 before compare/shift.
REQ-026 SHALL, without FP_ALIGN_FTZ_EN, process subnormals per REQ-015.

Structure
REQ-027 SHALL place EXP_W/FRAC_W defaults, MANT_W and the operand-class enum (ZERO, SUBNORM, NORM, INF, NAN) in shared package fp_pkg.
REQ-028 SHALL implement the right shift with sticky as sub-module fp_shift_sticky (parameter MANT_W; ports in, shamt, out).

Verification
REQ-029 SHALL cover x=3F800000, y=40000000 -> 2 cycles later out_exp=80, out_mant_big=4000000, out_mant_small=2000000, out_sign=0, out_sub=0.
REQ-030 SHALL cover x=4B800000, y=3F800001 -> out_exp=97, out_mant_small=0000005 (sticky set).
REQ-031 SHALL cover x=7F800000, y=FF800000 -> out_nan=1; x=7F800000, y=3F800000 -> out_inf=1, out_nan=0, out_sign=0.
REQ-032 SHALL cover out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, in_ready=0 afterwards, payload stable, order preserved after release.
REQ-033 SHALL cover rst asserted with both stages full -> next cycle out_valid=0, in_ready=1, outputs 0.
REQ-034 SHALL cover x=y=00000001 -> without macro out_mant_big=0000008, out_exp=01; with FP_ALIGN_FTZ_EN out_mant_big=0, out_zero=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point alignment datapath.
//   FP_EXP_W / FP_FRAC_W : default exponent and stored-fraction widths (binary32)
//   FP_MANT_W            : working mantissa width (hidden + fraction + guard/round/sticky)
//   fp_class_e           : operand classification
package fp_pkg;

    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_MANT_W = FP_FRAC_W + 4;

    typedef enum logic [2:0] {
        FP_ZERO    = 3'd0,
        FP_SUBNORM = 3'd1,
        FP_NORM    = 3'd2,
        FP_INF     = 3'd3,
        FP_NAN     = 3'd4
    } fp_class_e;

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational right shift that keeps a sticky bit.
// The result LSB is the OR of the shifted LSB and every bit shifted out, so no
// nonzero information is lost for later rounding. Shifts of MANT_W or more
// collapse the whole operand into the sticky position.
// Ports:
//   in    : mantissa to shift (MANT_W)
//   shamt : right shift amount (SH_W)
//   out   : shifted mantissa with sticky in bit 0 (MANT_W, combinational)
module fp_shift_sticky #(
    parameter int unsigned MANT_W = 27,
    parameter int unsigned SH_W   = 8
) (
    input  logic [MANT_W-1:0] in,
    input  logic [SH_W-1:0]   shamt,
    output logic [MANT_W-1:0] out
);

    logic [MANT_W-1:0] shifted;
    logic [MANT_W-1:0] lost_mask;
    logic              lost;
    logic              sticky_all;

    // Shifted value plus OR-reduction of the bits that fall off the bottom.
    always_comb begin
        shifted    = in >> shamt;
        lost_mask  = ~({MANT_W{1'b1}} << shamt);
        lost       = |(in & lost_mask);
        sticky_all = |in;
        if (32'(shamt) >= MANT_W) begin
            out = {{(MANT_W-1){1'b0}}, sticky_all};
        end else begin
            out = {shifted[MANT_W-1:1], shifted[0] | lost};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage exponent alignment front end for an IEEE-754 adder.
//   Stage 1: classify both operands, compare magnitudes, swap so "big" is the
//            larger one, compute the exponent difference.
//   Stage 2: shift the smaller mantissa right by the difference with sticky.
// Latency 2 cycles, one transfer per cycle, valid/ready on both sides.
// Build option: FP_ALIGN_FTZ_EN -- subnormal inputs are flushed to signed zero
// before compare and shift. Undefined by default (subnormals kept).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid, in_ready, x, y   : input handshake and operands
//   out_valid, out_ready       : output handshake
//   out_sign                   : sign of the larger-magnitude operand
//   out_sub                    : effective subtraction (sign_x ^ sign_y)
//   out_exp                    : effective exponent of the larger operand
//   out_mant_big/out_mant_small: aligned mantissas {hidden, frac, g, r, s}
//   out_nan, out_inf, out_zero : special-case flags
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int unsigned  EXP_W  = FP_EXP_W,
    parameter int unsigned  FRAC_W = FP_FRAC_W,
    localparam int unsigned MANT_W = FRAC_W + 4,
    localparam int unsigned OP_W   = 1 + EXP_W + FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic              out_sub,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant_big,
    output logic [MANT_W-1:0] out_mant_small,
    output logic              out_nan,
    output logic              out_inf,
    output logic              out_zero
);

    // Operand class from (possibly flushed) exponent and fraction.
    function automatic fp_class_e classify(input logic [EXP_W-1:0]  e,
                                           input logic [FRAC_W-1:0] f);
        fp_class_e c;
        if (e == '0) begin
            c = (f == '0) ? FP_ZERO : FP_SUBNORM;
        end else if (e == '1) begin
            c = (f == '0) ? FP_INF : FP_NAN;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

    // ---------------- operand decode ----------------
    logic              x_s, y_s;
    logic [EXP_W-1:0]  x_e, y_e;
    logic [FRAC_W-1:0] x_f, y_f;

    assign x_s = x[OP_W-1];
    assign y_s = y[OP_W-1];
    assign x_e = x[OP_W-2:FRAC_W];
    assign y_e = y[OP_W-2:FRAC_W];

`ifdef FP_ALIGN_FTZ_EN
    // Subnormals become signed zero: fraction dropped when exponent is 0.
    assign x_f = (x_e == '0) ? '0 : x[FRAC_W-1:0];
    assign y_f = (y_e == '0) ? '0 : y[FRAC_W-1:0];
`else
    assign x_f = x[FRAC_W-1:0];
    assign y_f = y[FRAC_W-1:0];
`endif

    // ---------------- stage 1 combinational ----------------
    fp_class_e         x_cls, y_cls;
    logic              x_ge_y;
    logic              big_s;
    logic [EXP_W-1:0]  big_e, sml_e;
    logic [FRAC_W-1:0] big_f, sml_f;
    logic [EXP_W-1:0]  big_ee, sml_ee;
    logic [MANT_W-1:0] big_m, sml_m;
    logic [EXP_W-1:0]  shamt;
    logic              nan_d, inf_d, zero_d;

    // Magnitude compare/swap, effective exponents and special-case flags.
    always_comb begin
        x_cls  = classify(x_e, x_f);
        y_cls  = classify(y_e, y_f);
        // Ties go to x.
        x_ge_y = {x_e, x_f} >= {y_e, y_f};
        big_s  = x_ge_y ? x_s : y_s;
        big_e  = x_ge_y ? x_e : y_e;
        big_f  = x_ge_y ? x_f : y_f;
        sml_e  = x_ge_y ? y_e : x_e;
        sml_f  = x_ge_y ? y_f : x_f;
        // Exponent field 0 means effective exponent 1 with no hidden bit.
        big_ee = (big_e == '0) ? EXP_W'(1) : big_e;
        sml_ee = (sml_e == '0) ? EXP_W'(1) : sml_e;
        big_m  = {big_e != '0, big_f, 3'b000};
        sml_m  = {sml_e != '0, sml_f, 3'b000};
        // Never negative: big has the larger {exp,frac}, hence the larger effective exponent.
        shamt  = big_ee - sml_ee;
        nan_d  = (x_cls == FP_NAN) || (y_cls == FP_NAN) ||
                 ((x_cls == FP_INF) && (y_cls == FP_INF) && (x_s != y_s));
        // An infinite operand always wins the magnitude compare, so big_s is its sign.
        inf_d  = !nan_d && ((x_cls == FP_INF) || (y_cls == FP_INF));
        zero_d = (x_cls == FP_ZERO) && (y_cls == FP_ZERO);
    end

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_load;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_adv;
    assign in_ready = !rst && s1_load;

    // ---------------- stage 1 registers ----------------
    logic              s1_sign, s1_sub;
    logic [EXP_W-1:0]  s1_exp;
    logic [EXP_W-1:0]  s1_shamt;
    logic [MANT_W-1:0] s1_mant_big, s1_mant_small;
    logic              s1_nan, s1_inf, s1_zero;

    // Capture classified/swapped operands whenever stage 1 can accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_sub        <= 1'b0;
            s1_exp        <= '0;
            s1_shamt      <= '0;
            s1_mant_big   <= '0;
            s1_mant_small <= '0;
            s1_nan        <= 1'b0;
            s1_inf        <= 1'b0;
            s1_zero       <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign       <= big_s;
                s1_sub        <= x_s ^ y_s;
                s1_exp        <= big_ee;
                s1_shamt      <= shamt;
                s1_mant_big   <= big_m;
                s1_mant_small <= sml_m;
                s1_nan        <= nan_d;
                s1_inf        <= inf_d;
                s1_zero       <= zero_d;
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic [MANT_W-1:0] aligned;

    fp_shift_sticky #(
        .MANT_W (MANT_W),
        .SH_W   (EXP_W)
    ) u_shift (
        .in    (s1_mant_small),
        .shamt (s1_shamt),
        .out   (aligned)
    );

    // Output registers; payload only changes when the output slot advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_sign       <= 1'b0;
            out_sub        <= 1'b0;
            out_exp        <= '0;
            out_mant_big   <= '0;
            out_mant_small <= '0;
            out_nan        <= 1'b0;
            out_inf        <= 1'b0;
            out_zero       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign       <= s1_sign;
                out_sub        <= s1_sub;
                out_exp        <= s1_exp;
                out_mant_big   <= s1_mant_big;
                out_mant_small <= aligned;
                out_nan        <= s1_nan;
                out_inf        <= s1_inf;
                out_zero       <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage (default EXP_W=8, FRAC_W=23).
module tb_fp_align_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x, y;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign, out_sub;
    logic [7:0]  out_exp;
    logic [26:0] out_mant_big, out_mant_small;
    logic        out_nan, out_inf, out_zero;

    fp_align_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .x              (x),
        .y              (y),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sign       (out_sign),
        .out_sub        (out_sub),
        .out_exp        (out_exp),
        .out_mant_big   (out_mant_big),
        .out_mant_small (out_mant_small),
        .out_nan        (out_nan),
        .out_inf        (out_inf),
        .out_zero       (out_zero)
    );

    typedef struct {
        logic        sign;
        logic        sub;
        logic [7:0]  exp;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        nan;
        logic        inf;
        logic        zero;
        bit          cmp_sign;
        bit          cmp_mant;
        bit          chk_lat;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    bit   lat_mode = 0;
    bit   rand_phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, expv);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic sb, input logic [7:0] e,
                                input logic [26:0] mb, input logic [26:0] ms,
                                input logic n, input logic i, input logic z);
        exp_t r;
        r.sign = s; r.sub = sb; r.exp = e; r.mb = mb; r.ms = ms;
        r.nan = n; r.inf = i; r.zero = z;
        r.cmp_sign = !n;
        r.cmp_mant = !n && !i;
        r.chk_lat  = 0;
        r.cyc      = 0;
        return r;
    endfunction

    // Reference: decode, swap on magnitude, bit-serial shift collecting sticky.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        int          ea, eb, be, se, bee, see, sh;
        logic [22:0] fa, fb, bf, sf;
        longint      mbig, msml;
        logic        bs, st;
        bit          a_nan, b_nan, a_inf, b_inf;
        ea = int'(a[30:23]); fa = a[22:0];
        eb = int'(b[30:23]); fb = b[22:0];
`ifdef FP_ALIGN_FTZ_EN
        if (ea == 0) fa = '0;
        if (eb == 0) fb = '0;
`endif
        a_nan = (ea == 255) && (fa != 0);
        b_nan = (eb == 255) && (fb != 0);
        a_inf = (ea == 255) && (fa == 0);
        b_inf = (eb == 255) && (fb == 0);
        if (longint'(ea) * 8388608 + longint'(fa) >= longint'(eb) * 8388608 + longint'(fb)) begin
            bs = a[31]; be = ea; bf = fa; se = eb; sf = fb;
        end else begin
            bs = b[31]; be = eb; bf = fb; se = ea; sf = fa;
        end
        bee  = (be == 0) ? 1 : be;
        see  = (se == 0) ? 1 : se;
        mbig = ((be != 0) ? (64'd1 << 26) : 64'd0) + longint'(bf) * 8;
        msml = ((se != 0) ? (64'd1 << 26) : 64'd0) + longint'(sf) * 8;
        sh   = bee - see;
        st   = 1'b0;
        for (int k = 0; k < sh; k++) begin
            st   = st | msml[0];
            msml = msml >> 1;
        end
        if (st) msml = msml | 64'd1;
        r.sign = bs;
        r.sub  = a[31] ^ b[31];
        r.exp  = 8'(bee);
        r.mb   = 27'(mbig);
        r.ms   = 27'(msml);
        r.nan  = a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]));
        r.inf  = !r.nan && (a_inf || b_inf);
        r.zero = (ea == 0) && (fa == 0) && (eb == 0) && (fb == 0);
        r.cmp_sign = !r.nan;
        r.cmp_mant = !r.nan && !r.inf;
        r.chk_lat  = 0;
        r.cyc      = 0;
        return r;
    endfunction

    // Monitor: push on input transfer, pop/compare on output transfer, check hold while stalled.
    initial begin
        exp_t        e;
        exp_t        t;
        bit          prev_stall = 0;
        logic [13:0] held_ctl;
        logic [53:0] held_mant;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_ctl", 64'({out_valid, out_sign, out_sub, out_exp, out_nan, out_inf, out_zero}),
                             64'(held_ctl));
                    check_eq("hold_mant", 64'({out_mant_big, out_mant_small}), 64'(held_mant));
                end
                if (out_valid && !out_ready) begin
                    prev_stall = 1;
                    held_ctl   = {out_valid, out_sign, out_sub, out_exp, out_nan, out_inf, out_zero};
                    held_mant  = {out_mant_big, out_mant_small};
                end else begin
                    prev_stall = 0;
                end
                if (out_valid && out_ready) begin
                    check_eq("sb_nonempty", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check_eq("nan", 64'(out_nan), 64'(e.nan));
                        check_eq("inf", 64'(out_inf), 64'(e.inf));
                        check_eq("zero", 64'(out_zero), 64'(e.zero));
                        check_eq("sub", 64'(out_sub), 64'(e.sub));
                        if (e.cmp_sign) check_eq("sign", 64'(out_sign), 64'(e.sign));
                        if (e.cmp_mant) begin
                            check_eq("exp", 64'(out_exp), 64'(e.exp));
                            check_eq("mant_big", 64'(out_mant_big), 64'(e.mb));
                            check_eq("mant_small", 64'(out_mant_small), 64'(e.ms));
                        end
                        if (e.chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (in_valid && in_ready) begin
                    t     = cur_exp;
                    t.cyc = cyc;
                    q.push_back(t);
                    acc_cnt++;
                end
            end
        end
    end

    // Present one operand pair until accepted; called at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n;
        cur_exp         = e;
        cur_exp.chk_lat = lat_mode;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, "_ctl"}, 64'({out_sign, out_sub, out_exp, out_nan, out_inf, out_zero}), 64'd0);
        check_eq({tag, "_mant"}, 64'({out_mant_big, out_mant_small}), 64'd0);
    endtask

    logic [31:0] sx [5];
    logic [31:0] sy [5];

    initial begin
        logic [31:0] a, b;
        int          idx;
        int          acc0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        out_ready = 1'b1;
        rand_phase = 1;

        // Reset, no acceptance while rst is high.
        @(posedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_no_accept", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expectations.
        lat_mode = 1;
        send(32'h3F800000, 32'h40000000, mk(0, 0, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 0));
        send(32'h4B800000, 32'h3F800001, mk(0, 0, 8'h97, 27'h4000000, 27'h0000005, 0, 0, 0));
        send(32'h7F800000, 32'hFF800000, mk(0, 1, 8'h00, 27'h0, 27'h0, 1, 0, 0));
        send(32'h7F800000, 32'h3F800000, mk(0, 0, 8'h00, 27'h0, 27'h0, 0, 1, 0));
        send(32'h3F800000, 32'hFF800000, mk(1, 1, 8'h00, 27'h0, 27'h0, 0, 1, 0));
        send(32'h7FC00000, 32'h3F800000, mk(0, 0, 8'h00, 27'h0, 27'h0, 1, 0, 0));
        send(32'hBF800000, 32'h3F800000, mk(1, 1, 8'h7F, 27'h4000000, 27'h4000000, 0, 0, 0));
        send(32'h00000000, 32'h80000000, mk(0, 1, 8'h01, 27'h0, 27'h0, 0, 0, 1));
        send(32'h4D000000, 32'h3F800000, mk(0, 0, 8'h9A, 27'h4000000, 27'h0000001, 0, 0, 0));
        send(32'h4C000000, 32'h3FC00000, mk(0, 0, 8'h98, 27'h4000000, 27'h0000003, 0, 0, 0));
`ifdef FP_ALIGN_FTZ_EN
        send(32'h00000001, 32'h00000001, mk(0, 0, 8'h01, 27'h0, 27'h0, 0, 0, 1));
        send(32'h7F000000, 32'h00000001, mk(0, 0, 8'hFE, 27'h4000000, 27'h0, 0, 0, 0));
`else
        send(32'h00000001, 32'h00000001, mk(0, 0, 8'h01, 27'h0000008, 27'h0000008, 0, 0, 0));
        send(32'h7F000000, 32'h00000001, mk(0, 0, 8'hFE, 27'h4000000, 27'h0000001, 0, 0, 0));
`endif
        drain();

        // Random operands with random backpressure and input gaps.
        lat_mode = 0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    a = $urandom;
                    case ($urandom_range(0, 3))
                        0: b = $urandom;
                        1: b = {1'($urandom_range(0, 1)), 8'(32'(a[30:23]) + $urandom_range(0, 30) - 32'd15),
                                23'($urandom)};
                        2: b = {1'($urandom_range(0, 1)), a[30:0]};
                        default: b = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
                    endcase
                    if ($urandom_range(0, 1) == 1) send(a, b, model(a, b));
                    else send(b, a, model(b, a));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_phase = 0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: five cycles of offered input, only two fit.
        sx[0] = 32'h3F800000; sy[0] = 32'h40400000;
        sx[1] = 32'hC1200000; sy[1] = 32'h3DCCCCCD;
        sx[2] = 32'h42C80000; sy[2] = 32'h42C80001;
        sx[3] = 32'h00400000; sy[3] = 32'h00000003;
        sx[4] = 32'h3F000000; sy[4] = 32'hBF000000;
        out_ready = 1'b0;
        acc0      = acc_cnt;
        idx       = 0;
        for (int i = 0; i < 5; i++) begin
            cur_exp  = model(sx[idx], sy[idx]);
            x        = sx[idx];
            y        = sy[idx];
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready && idx < 4) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("stall_accepted", 64'(acc_cnt - acc0), 64'd2);
        @(negedge clk);
        check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        check_eq("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with both stages full discards everything.
        out_ready = 1'b0;
        send(32'h40A00000, 32'h3F800000, model(32'h40A00000, 32'h3F800000));
        send(32'hC0A00000, 32'h3F800000, model(32'hC0A00000, 32'h3F800000));
        @(negedge clk);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("flush");
        check_eq("flush_queue", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Pipeline still works after the flush.
        lat_mode = 1;
        send(32'h3F800000, 32'h40000000, mk(0, 0, 8'h80, 27'h4000000, 27'h2000000, 0, 0, 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
